// File: rtl/direct_mapped_cache.sv
// direct_mapped_cache
//   Write-back, write-allocate, direct-mapped cache with one word per line,
//   placed between a CPU (valid/ready request, one-cycle response pulse) and
//   a MainMemory with 1-cycle read latency.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   cpu_req_*         CPU request: valid/ready handshake, write flag, addr, wdata
//   cpu_resp_*        registered response: valid pulse, load data (0 on stores), hit flag
//   mem_read/mem_write/mem_address/mem_write_data
//                     Moore outputs to MainMemory, decoded from the state register
//   mem_read_data     MainMemory read data, valid the cycle after mem_read
//
// Configuration
//   CACHE_STATS_EN    when defined, adds saturating 16-bit hit_count/miss_count outputs.
module direct_mapped_cache #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                  cpu_resp_hit,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_e;

    state_e state_q, state_d;

    // Latched request
    logic                  req_write_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;

    // Line storage; only valid/dirty are reset
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_WIDTH-1:0]  tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_hit_q;

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   hit;
    logic                   accept;

    assign idx     = req_addr_q[INDEX_WIDTH-1:0];
    assign req_tag = req_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
    assign accept  = cpu_req_valid && cpu_req_ready;

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;

    // Next state and Moore outputs
    always_comb begin
        state_d        = state_q;
        cpu_req_ready  = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_q)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit)                          state_d = IDLE;
                else if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
                else                              state_d = ALLOCATE;
            end
            WRITEBACK: begin
                mem_write      = 1'b1;
                mem_address    = {tag_q[idx], idx};
                mem_write_data = data_q[idx];
                state_d        = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = req_addr_q;
                state_d     = FILL;
            end
            FILL: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, flags and response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            if (accept) begin
                req_write_q <= cpu_req_write;
                req_addr_q  <= cpu_req_addr;
                req_wdata_q <= cpu_req_wdata;
            end
            if (state_q == COMPARE && hit) begin
                resp_valid_q <= 1'b1;
                resp_hit_q   <= 1'b1;
                resp_rdata_q <= req_write_q ? '0 : data_q[idx];
                if (req_write_q) dirty_q[idx] <= 1'b1;
            end
            if (state_q == FILL) begin
                resp_valid_q <= 1'b1;
                resp_hit_q   <= 1'b0;
                resp_rdata_q <= req_write_q ? '0 : mem_read_data;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= req_write_q;
            end
        end
    end

    // Tag/data arrays: not reset, writes suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == COMPARE && hit && req_write_q) begin
                data_q[idx] <= req_wdata_q;
            end
            if (state_q == FILL) begin
                tag_q[idx]  <= req_tag;
                data_q[idx] <= req_write_q ? req_wdata_q : mem_read_data;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Counted on the same edge that raises cpu_resp_valid; saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == COMPARE && hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (state_q == FILL && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule
